alu_share_arbiter: RTL

Shares the single 32-bit ALU (ALUS select, a/b operands, ALURes/SLT/ZERO/SLTU outputs) between two requesters, for example the execute stage and the branch/address unit. It uses a round-robin arbiter with valid/ready handshakes. Each requester has a one-entry registered response buffer. The block drives the ALU combinationally from the granted request and captures the ALU outputs at the clock edge, returning the result one cycle after acceptance.

---
 rtl/alu_share_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Lets two requesters share one 32-bit ALU. A round-robin arbiter picks at
// most one eligible request per cycle, drives the ALU combinationally from
// that request, and captures the ALU outputs into the winner's one-entry
// response buffer at the next rising edge.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN_valid/ready        request handshake for requester N (N = 0, 1)
//   reqN_op/a/b/tag         ALU select, operands and opaque tag
//   rspN_valid/ready        response handshake for requester N
//   rspN_res/flags/tag      captured ALURes, {SLTU, SLT, ZERO} and echoed tag
//   alu_s/a/b               to the shared ALU
//   alu_res/slt/zero/sltu   from the shared ALU
//   grant_id                granted requester; meaningful only when a
//                           reqN_ready is high
module alu_share_arbiter #(
    parameter int TAG_W   = 4,
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_res,
    output logic [2:0]       rsp0_flags,
    output logic [TAG_W-1:0] rsp0_tag,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_res,
    output logic [2:0]       rsp1_flags,
    output logic [TAG_W-1:0] rsp1_tag,

    output logic             alu_s,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_res,
    input  logic             alu_slt,
    input  logic             alu_zero,
    input  logic             alu_sltu,

    output logic             grant_id
);

    logic             rr_q, rr_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic [31:0]      rsp0_res_q, rsp0_res_d;
    logic [2:0]       rsp0_flags_q, rsp0_flags_d;
    logic [TAG_W-1:0] rsp0_tag_q, rsp0_tag_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [31:0]      rsp1_res_q, rsp1_res_d;
    logic [2:0]       rsp1_flags_q, rsp1_flags_d;
    logic [TAG_W-1:0] rsp1_tag_q, rsp1_tag_d;

    logic elig0, elig1, gnt0, gnt1;

    always_comb begin
        // A buffer can take a new result if it is empty or being drained now.
        // rst_n is folded in so no request is accepted while reset is held.
        elig0 = rst_n && req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1 = rst_n && req1_valid && (!rsp1_valid_q || rsp1_ready);

        gnt0 = elig0 && (!elig1 || (rr_q == 1'b0));
        gnt1 = elig1 && (!elig0 || (rr_q == 1'b1));

        // Only contended grants move the pointer, to the loser.
        rr_d = (elig0 && elig1) ? gnt0 : rr_q;

        alu_s = 1'b0;
        alu_a = 32'd0;
        alu_b = 32'd0;
        if (gnt0) begin
            alu_s = req0_op;
            alu_a = req0_a;
            alu_b = req0_b;
        end else if (gnt1) begin
            alu_s = req1_op;
            alu_a = req1_a;
            alu_b = req1_b;
        end

        rsp0_valid_d = rsp0_valid_q;
        rsp0_res_d   = rsp0_res_q;
        rsp0_flags_d = rsp0_flags_q;
        rsp0_tag_d   = rsp0_tag_q;
        if (gnt0) begin
            rsp0_valid_d = 1'b1;
            rsp0_res_d   = alu_res;
            rsp0_flags_d = {alu_sltu, alu_slt, alu_zero};
            rsp0_tag_d   = req0_tag;
        end else if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        rsp1_valid_d = rsp1_valid_q;
        rsp1_res_d   = rsp1_res_q;
        rsp1_flags_d = rsp1_flags_q;
        rsp1_tag_d   = rsp1_tag_q;
        if (gnt1) begin
            rsp1_valid_d = 1'b1;
            rsp1_res_d   = alu_res;
            rsp1_flags_d = {alu_sltu, alu_slt, alu_zero};
            rsp1_tag_d   = req1_tag;
        end else if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= RR_INIT;
            rsp0_valid_q <= 1'b0;
            rsp0_res_q   <= 32'd0;
            rsp0_flags_q <= 3'd0;
            rsp0_tag_q   <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_res_q   <= 32'd0;
            rsp1_flags_q <= 3'd0;
            rsp1_tag_q   <= '0;
        end else begin
            rr_q         <= rr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_res_q   <= rsp0_res_d;
            rsp0_flags_q <= rsp0_flags_d;
            rsp0_tag_q   <= rsp0_tag_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_res_q   <= rsp1_res_d;
            rsp1_flags_q <= rsp1_flags_d;
            rsp1_tag_q   <= rsp1_tag_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign grant_id   = gnt1;

    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_res   = rsp0_res_q;
    assign rsp0_flags = rsp0_flags_q;
    assign rsp0_tag   = rsp0_tag_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_res   = rsp1_res_q;
    assign rsp1_flags = rsp1_flags_q;
    assign rsp1_tag   = rsp1_tag_q;

endmodule
